uptime_msg_gen: RTL and testbench

//  Upstream message source for serial_debug. Keeps an HH:MM:SS uptime in BCD counters on clk_1hz.

---
 rtl/uptime_msg_gen_pkg.sv | 41 ++++
 rtl/uptime_msg_gen_bcd_digit_counter.sv | 31 +++
 rtl/uptime_msg_gen.sv | 90 +++++++++
 tb/tb_uptime_msg_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uptime_msg_gen_pkg.sv
// Shared ASCII constants, uptime record and line formatter for the uptime debug message source.
// The line layout is fixed: "T=HH:MM:SS D=X\r\n", first character in the top byte.
package uptime_msg_gen_pkg;

  localparam int MSG_LEN = 16;
  localparam int DATA_W  = 8 * MSG_LEN;

  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_D     = 8'h44;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef struct packed {
    logic [3:0] hour_t;
    logic [3:0] hour_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } uptime_t;

  function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] hex2ascii(input logic [3:0] h);
    return (h < 4'hA) ? (8'h30 + {4'h0, h}) : (8'h37 + {4'h0, h});
  endfunction

  function automatic logic [DATA_W-1:0] format_line(input uptime_t t, input logic [3:0] drop);
    return {ASC_T, ASC_EQ,
            bcd2ascii(t.hour_t), bcd2ascii(t.hour_u), ASC_COLON,
            bcd2ascii(t.min_t),  bcd2ascii(t.min_u),  ASC_COLON,
            bcd2ascii(t.sec_t),  bcd2ascii(t.sec_u),
            ASC_SP, ASC_D, ASC_EQ, hex2ascii(drop), ASC_CR, ASC_LF};
  endfunction

endpackage

// File: rtl/uptime_msg_gen_bcd_digit_counter.sv
// One BCD digit of the uptime chain: counts 0..MAX on inc, carries out on the wrap edge.
// digit_nxt exposes the value the digit takes at the next edge so the formatter needs no extra cycle.
module bcd_digit_counter #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic [3:0] digit_nxt,
  output logic       carry
);

  always_comb begin
    carry     = inc & (digit == MAX);
    digit_nxt = digit;
    if (clr || carry)
      digit_nxt = 4'd0;
    else if (inc)
      digit_nxt = digit + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      digit <= 4'd0;
    else
      digit <= digit_nxt;
  end

endmodule

// File: rtl/uptime_msg_gen.sv
// Once-per-second uptime line generator feeding serial_debug: BCD HH:MM:SS plus a saturating
// count of lines dropped while the serializer was busy.
module uptime_msg_gen
  import uptime_msg_gen_pkg::*;
#(
  parameter int HOURS_MAX = 23,
  parameter int MSG_LEN   = 16
) (
  input  logic                 clk_1hz,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 busy,
  output logic [8*MSG_LEN-1:0] data,
  output logic                 send,
  output logic [3:0]           drop_cnt
);

  localparam logic [3:0] HMAX_T = 4'(HOURS_MAX / 10);
  localparam logic [3:0] HMAX_U = 4'(HOURS_MAX % 10);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  logic [3:0] sec_u, sec_t, min_u, min_t, hour_u, hour_t;
  logic [3:0] sec_u_nxt, sec_t_nxt, min_u_nxt, min_t_nxt, hour_u_nxt, hour_t_nxt;
  logic       c_sec_u, c_sec_t, c_min_u, c_min_t, c_hour_u;
  logic       hour_wrap;
  uptime_t    nxt;

  bcd_digit_counter #(.MAX(4'd9)) u_sec_u (
    .clk(clk_1hz), .rst(rst), .inc(enable), .clr(1'b0),
    .digit(sec_u), .digit_nxt(sec_u_nxt), .carry(c_sec_u));

  bcd_digit_counter #(.MAX(4'd5)) u_sec_t (
    .clk(clk_1hz), .rst(rst), .inc(c_sec_u), .clr(1'b0),
    .digit(sec_t), .digit_nxt(sec_t_nxt), .carry(c_sec_t));

  bcd_digit_counter #(.MAX(4'd9)) u_min_u (
    .clk(clk_1hz), .rst(rst), .inc(c_sec_t), .clr(1'b0),
    .digit(min_u), .digit_nxt(min_u_nxt), .carry(c_min_u));

  bcd_digit_counter #(.MAX(4'd5)) u_min_t (
    .clk(clk_1hz), .rst(rst), .inc(c_min_u), .clr(1'b0),
    .digit(min_t), .digit_nxt(min_t_nxt), .carry(c_min_t));

  // The hour wrap overrides the units carry, which matters when HOURS_MAX ends in 9.
  assign hour_wrap = c_min_t & (hour_t == HMAX_T) & (hour_u == HMAX_U);

  bcd_digit_counter #(.MAX(4'd9)) u_hour_u (
    .clk(clk_1hz), .rst(rst), .inc(c_min_t), .clr(hour_wrap),
    .digit(hour_u), .digit_nxt(hour_u_nxt), .carry(c_hour_u));

  always_comb begin
    hour_t_nxt = hour_t;
    if (hour_wrap)
      hour_t_nxt = 4'd0;
    else if (c_hour_u)
      hour_t_nxt = hour_t + 4'd1;
  end

  always_ff @(posedge clk_1hz) begin
    if (rst)
      hour_t <= 4'd0;
    else
      hour_t <= hour_t_nxt;
  end

  assign nxt = {hour_t_nxt, hour_u_nxt, min_t_nxt, min_u_nxt, sec_t_nxt, sec_u_nxt};

  // Output stage: line built from next-state time and the pre-increment drop count.
  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      drop_cnt <= 4'h0;
      send     <= 1'b0;
      data     <= format_line('0, 4'h0);
    end else if (enable) begin
      if (busy) begin
        send     <= 1'b0;
        drop_cnt <= sat_inc4(drop_cnt);
      end else begin
        send     <= 1'b1;
        data     <= format_line(nxt, drop_cnt);
      end
    end else begin
      send <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uptime_msg_gen.sv
// Scoreboard bench for uptime_msg_gen: stimulus pushes expected lines, a monitor pops and compares.
// Two instances share inputs: HOURS_MAX=23 and HOURS_MAX=19 (wrap where the units digit carries too).
module tb_uptime_msg_gen;

  typedef struct {
    int           step;
    logic [127:0] data;
    logic         send;
    logic [3:0]   drop;
  } exp_t;

  logic         clk_1hz = 1'b0;
  logic         rst = 1'b1, enable = 1'b0, busy = 1'b0;
  logic [127:0] data0, data1;
  logic         send0, send1;
  logic [3:0]   drop0, drop1;

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  exp_t q0[$];
  exp_t q1[$];

  int           m_secs[2];
  int           m_drop[2];
  logic [127:0] m_data[2];
  logic         m_send[2];
  int           period[2];

  logic         ovr[2];
  logic [127:0] ovr_data[2];
  logic         ovr_send[2];
  logic [3:0]   ovr_drop[2];

  localparam logic [127:0] RST_LINE = "T=00:00:00 D=0\r\n";

  always #5 clk_1hz = ~clk_1hz;

  uptime_msg_gen #(.HOURS_MAX(23), .MSG_LEN(16)) dut0 (
    .clk_1hz(clk_1hz), .rst(rst), .enable(enable), .busy(busy),
    .data(data0), .send(send0), .drop_cnt(drop0));

  uptime_msg_gen #(.HOURS_MAX(19), .MSG_LEN(16)) dut1 (
    .clk_1hz(clk_1hz), .rst(rst), .enable(enable), .busy(busy),
    .data(data1), .send(send1), .drop_cnt(drop1));

  function automatic logic [7:0] dg(input int x);
    return 8'h30 + 8'(x);
  endfunction

  function automatic logic [7:0] hx(input int x);
    return (x < 10) ? (8'h30 + 8'(x)) : (8'h41 + 8'(x - 10));
  endfunction

  function automatic logic [127:0] fmt(input int secs, input int drop);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {"T=", dg(h / 10), dg(h % 10), ":", dg(m / 10), dg(m % 10), ":",
            dg(s / 10), dg(s % 10), " D=", hx(drop), "\r\n"};
  endfunction

  task automatic hand(input int k, input logic [127:0] d, input logic s, input logic [3:0] dr);
    ovr[k]      = 1'b1;
    ovr_data[k] = d;
    ovr_send[k] = s;
    ovr_drop[k] = dr;
  endtask

  task automatic step(input logic r, input logic e, input logic b);
    exp_t x;
    @(negedge clk_1hz);
    rst = r; enable = e; busy = b;
    step_no++;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_secs[k] = 0; m_drop[k] = 0; m_data[k] = fmt(0, 0); m_send[k] = 1'b0;
      end else if (!e) begin
        m_send[k] = 1'b0;
      end else begin
        m_secs[k] = (m_secs[k] + 1) % period[k];
        if (!b) begin
          m_data[k] = fmt(m_secs[k], m_drop[k]);
          m_send[k] = 1'b1;
        end else begin
          m_send[k] = 1'b0;
          m_drop[k] = (m_drop[k] < 15) ? m_drop[k] + 1 : 15;
        end
      end
      x.step = step_no;
      if (ovr[k]) begin
        x.data = ovr_data[k]; x.send = ovr_send[k]; x.drop = ovr_drop[k];
        ovr[k] = 1'b0;
      end else begin
        x.data = m_data[k]; x.send = m_send[k]; x.drop = 4'(m_drop[k]);
      end
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
  endtask

  task automatic check_one(input int k, input exp_t x, input logic [127:0] d,
                           input logic s, input logic [3:0] dr);
    n_tests += 3;
    if (d !== x.data) begin
      n_fail++;
      $display("FAIL data dut%0d step %0d: got %h want %h", k, x.step, d, x.data);
    end
    if (s !== x.send) begin
      n_fail++;
      $display("FAIL send dut%0d step %0d: got %b want %b", k, x.step, s, x.send);
    end
    if (dr !== x.drop) begin
      n_fail++;
      $display("FAIL drop_cnt dut%0d step %0d: got %h want %h", k, x.step, dr, x.drop);
    end
  endtask

  // Monitor: one expectation per DUT per clock edge, sampled just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_1hz);
      #1;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        check_one(0, x, data0, send0, drop0);
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        check_one(1, x, data1, send1, drop1);
      end
    end
  end

  initial begin
    period[0] = 24 * 3600;
    period[1] = 20 * 3600;
    for (int k = 0; k < 2; k++) begin
      m_secs[k] = 0; m_drop[k] = 0; m_data[k] = '0; m_send[k] = 1'b0; ovr[k] = 1'b0;
      ovr_data[k] = '0; ovr_send[k] = 1'b0; ovr_drop[k] = 4'h0;
    end

    // Reset, then hold with enable low.
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) hand(0, RST_LINE, 1'b0, 4'h0);
      step(0, 0, 0);
    end

    // 61 advances from reset.
    for (int i = 0; i < 61; i++) begin
      if (i == 60) hand(0, "T=00:01:01 D=0\r\n", 1'b1, 4'h0);
      step(0, 1, 0);
    end

    // Drops while busy, starting from 00:00:10.
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) hand(0, "T=00:00:10 D=0\r\n", 1'b0, 4'h3);
      step(0, 1, 1);
    end
    hand(0, "T=00:00:14 D=3\r\n", 1'b1, 4'h3);
    step(0, 1, 0);

    // Saturation of the drop counter.
    for (int i = 0; i < 20; i++) begin
      if (i == 19) hand(0, "T=00:00:14 D=3\r\n", 1'b0, 4'hF);
      step(0, 1, 1);
    end
    hand(0, "T=00:00:35 D=F\r\n", 1'b1, 4'hF);
    step(0, 1, 0);

    // Reset mid-run with send high and busy asserted.
    for (int i = 0; i < 272; i++) begin
      if (i == 271) hand(0, "T=00:05:07 D=F\r\n", 1'b1, 4'hF);
      step(0, 1, 0);
    end
    hand(0, RST_LINE, 1'b0, 4'h0);
    hand(1, RST_LINE, 1'b0, 4'h0);
    step(1, 1, 1);
    hand(0, "T=00:00:01 D=0\r\n", 1'b1, 4'h0);
    step(0, 1, 0);

    // Full day: both hour wraps.
    for (int t = 2; t <= 86400; t++) begin
      if (t == 71999) hand(1, "T=19:59:59 D=0\r\n", 1'b1, 4'h0);
      if (t == 72000) hand(1, RST_LINE, 1'b1, 4'h0);
      if (t == 86399) hand(0, "T=23:59:59 D=0\r\n", 1'b1, 4'h0);
      if (t == 86400) hand(0, RST_LINE, 1'b1, 4'h0);
      step(0, 1, 0);
    end

    @(posedge clk_1hz);
    #2;
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
